br_resolve: RTL
===============

BR_RESOLVE -- requirements
Module: br_resolve

Interface
REQ-001 SHALL have parameter NUM_DEPTH_BIT, default 2: log2 of in-flight branch queue depth (4 entries).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on posedge.
REQ-003 SHALL have port rst  input  1  synchronous active-high reset.
REQ-004 SHALL have port PushValid_i  input  1  fetch stage records one predicted branch this cycle.
REQ-005 SHALL have port PushAddr_i  input  32  PC of the pushed branch.
REQ-006 SHALL have port PushHit_i  input  1  predictor Hit at fetch (predicted taken).
REQ-007 SHALL have port PushTarget_i  input  32  predictor ReadTarget at fetch.
REQ-008 SHALL have port Full_o  output  1  queue holds 2^NUM_DEPTH_BIT entries.
REQ-009 SHALL have port Empty_o  output  1  queue holds zero entries.
REQ-010 SHALL have port ResValid_i  input  1  execute stage resolves the oldest in-flight branch.
REQ-011 SHALL have port ResTaken_i  input  1  actual branch outcome.
REQ-012 SHALL have port ResTarget_i  input  32  actual taken target.
REQ-013 SHALL have port Redirect_o  output  1  one-cycle pulse: fetch must restart at RedirectPc_o.
REQ-014 SHALL have port RedirectPc_o  output  32  corrected fetch PC.
REQ-015 SHALL have port WriteValid_o  output  1  predictor update strobe.
REQ-016 SHALL have port BranchTaken_o  output  1  outcome for predictor 2-bit counter update.
REQ-017 SHALL have port WriteAddr_o  output  32  branch PC for predictor index.
REQ-018 SHALL have port WriteTarget_o  output  32  target for predictor target table.
REQ-019 SHALL have port MissCount_o  output  16  saturating mispredict counter.

Function
REQ-020 SHALL implement an in-order FIFO of {addr, hit, target}; push at tail, pop at head.
REQ-021 SHALL accept a push only when PushValid_i=1, Full_o=0, and state is NORMAL; otherwise the push is dropped.
REQ-022 SHALL pop the head when ResValid_i=1 and Empty_o=0; ResValid_i with Empty_o=1 SHALL be ignored (no update, no redirect).
REQ-023 SHALL derive Full_o/Empty_o combinationally from the registered entry count; a simultaneous pop does not unblock a push while full.
REQ-024 SHALL allow simultaneous push and pop when not full and not empty; count unchanged.
REQ-025 SHALL wrap head/tail pointers modulo 2^NUM_DEPTH_BIT.
REQ-026 SHALL declare a mispredict when head.hit != ResTaken_i, or head.hit=1 and ResTaken_i=1 and head.target[31:2] != ResTarget_i[31:2].
REQ-027 SHALL register all resolve outputs: one cycle after a valid pop, WriteValid_o=1, BranchTaken_o=ResTaken_i, WriteAddr_o=head.addr, WriteTarget_o={ResTarget_i[31:2],2'b00}.
REQ-028 SHALL, on mispredict, pulse Redirect_o in the same cycle as WriteValid_o, with RedirectPc_o = {ResTarget_i[31:2],2'b00} if taken, else head.addr+4 (mod 2^32).
REQ-029 SHALL, on mispredict, clear the queue (count=0, head=tail) so that it is empty in the Redirect_o cycle, discarding all younger entries including any push in the resolving cycle.
REQ-030 SHALL use FSM NORMAL/FLUSH: NORMAL->FLUSH on mispredict pop; FLUSH->NORMAL unconditionally after one cycle; in FLUSH, pushes are dropped and ResValid_i is ignored.
REQ-031 SHALL increment MissCount_o by 1 per mispredict, saturating at 16'hFFFF.
REQ-032 SHALL hold WriteValid_o and Redirect_o at 0 in cycles without a valid pop.

Reset
REQ-033 SHALL, on rst=1 at posedge, set count, pointers, and MissCount_o to 0, state to NORMAL, and WriteValid_o, Redirect_o, BranchTaken_o, WriteAddr_o, WriteTarget_o, RedirectPc_o to 0; Empty_o=1, Full_o=0.
REQ-034 SHALL give rst priority over simultaneous push/pop, and a mid-flush rst SHALL return to NORMAL with an empty queue.

Structure
REQ-035 SHALL place state encodings (S_NORMAL, S_FLUSH) and the entry field widths in a shared package used with the predictor.
REQ-036 SHALL implement the queue as one sub-module, br_fifo; compare, FSM, and counter stay in br_resolve.

Verification
REQ-037 Reset, then push {0x100,hit=1,0x200}, resolve taken 0x200 -> next cycle WriteValid_o=1, BranchTaken_o=1, WriteAddr_o=0x100, Redirect_o=0, MissCount_o=0.
REQ-038 Push {0x104,hit=0}, resolve taken 0x303 -> Redirect_o=1, RedirectPc_o=0x300, WriteTarget_o=0x300, MissCount_o=1.
REQ-039 Push {0x108,hit=1,0x400}, resolve not-taken -> Redirect_o=1, RedirectPc_o=0x10C.
REQ-040 Push 4 entries, then a 5th push -> Full_o=1 and the 5th is dropped; 4 pops return entries in order; ResValid_i after that yields WriteValid_o=0.
REQ-041 3 entries queued, head mispredicts while PushValid_i=1 -> Empty_o=1 in the Redirect_o cycle, push in the FLUSH cycle dropped, push accepted in the following cycle.
REQ-042 Preload MissCount_o near saturation by forcing 0xFFFF mispredicts (or a bench override) -> stays 0xFFFF; assert rst mid-flush -> all outputs 0, Empty_o=1.

Source files
------------

// File: rtl/br_resolve_pkg.sv
// Shared branch-queue types: FSM encodings and entry layout,
// also used by the predictor side.
package br_resolve_pkg;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned TGT_W  = 32;

   typedef enum logic {
      S_NORMAL = 1'b0,
      S_FLUSH  = 1'b1
   } br_state_e;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic              hit;
      logic [TGT_W-1:0]  target;
   } br_entry_t;

   function automatic logic [TGT_W-1:0] word_align(
      input logic [TGT_W-1:0] a
   );
      return {a[TGT_W-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/br_fifo.sv
// In-order queue of predicted branches; head is visible combinationally,
// clear_i empties the queue and wins over push/pop.
module br_fifo
   import br_resolve_pkg::*;
#(
   parameter int unsigned DEPTH_BIT = 2
) (
   input  logic      clk,
   input  logic      rst,
   input  logic      push_i,
   input  br_entry_t wdata_i,
   input  logic      pop_i,
   input  logic      clear_i,
   output br_entry_t rdata_o,
   output logic      full_o,
   output logic      empty_o
);

   localparam int unsigned DEPTH = 1 << DEPTH_BIT;
   localparam int unsigned CNT_W = DEPTH_BIT + 1;

   br_entry_t            mem_q [DEPTH];
   logic [DEPTH_BIT-1:0] head_q, head_d;
   logic [DEPTH_BIT-1:0] tail_q, tail_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;

   assign full_o  = (cnt_q == CNT_W'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign rdata_o = mem_q[head_q];

   always_comb begin
      head_d = head_q;
      tail_d = tail_q;
      cnt_d  = cnt_q;
      if (clear_i) begin
         head_d = '0;
         tail_d = '0;
         cnt_d  = '0;
      end else begin
         if (push_i) tail_d = tail_q + 1'b1;
         if (pop_i)  head_d = head_q + 1'b1;
         if (push_i && !pop_i)      cnt_d = cnt_q + 1'b1;
         else if (pop_i && !push_i) cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head_q <= '0;
         tail_q <= '0;
         cnt_q  <= '0;
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
         cnt_q  <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_i) mem_q[tail_q] <= wdata_i;
   end

endmodule

// File: rtl/br_resolve.sv
// Branch resolution: compares the oldest prediction with the actual
// outcome, updates the predictor and redirects fetch on a mispredict.
module br_resolve
   import br_resolve_pkg::*;
#(
   parameter int unsigned NUM_DEPTH_BIT = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        PushValid_i,
   input  logic [31:0] PushAddr_i,
   input  logic        PushHit_i,
   input  logic [31:0] PushTarget_i,
   output logic        Full_o,
   output logic        Empty_o,
   input  logic        ResValid_i,
   input  logic        ResTaken_i,
   input  logic [31:0] ResTarget_i,
   output logic        Redirect_o,
   output logic [31:0] RedirectPc_o,
   output logic        WriteValid_o,
   output logic        BranchTaken_o,
   output logic [31:0] WriteAddr_o,
   output logic [31:0] WriteTarget_o,
   output logic [15:0] MissCount_o
);

   br_state_e   state_q;
   br_entry_t   head;
   br_entry_t   push_ent;
   logic        push_ok, pop_ok, miss;
   logic        wr_valid_q, redir_q, taken_q;
   logic [31:0] waddr_q, wtgt_q, rpc_q;
   logic [15:0] miss_q, miss_d;

   assign push_ent = '{addr: PushAddr_i, hit: PushHit_i,
                       target: PushTarget_i};

   assign push_ok = PushValid_i && !Full_o && (state_q == S_NORMAL);
   assign pop_ok  = ResValid_i && !Empty_o && (state_q == S_NORMAL);

   // Only bits [31:2] of a target matter; targets are word aligned.
   assign miss = pop_ok &&
      ((head.hit != ResTaken_i) ||
       (head.hit && ResTaken_i &&
        (head.target[31:2] != ResTarget_i[31:2])));

   assign miss_d = (miss && (miss_q != 16'hFFFF)) ? miss_q + 16'd1
                                                  : miss_q;

   br_fifo #(.DEPTH_BIT(NUM_DEPTH_BIT)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push_ok),
      .wdata_i (push_ent),
      .pop_i   (pop_ok),
      .clear_i (miss),
      .rdata_o (head),
      .full_o  (Full_o),
      .empty_o (Empty_o)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_NORMAL;
         wr_valid_q <= 1'b0;
         redir_q    <= 1'b0;
         taken_q    <= 1'b0;
         waddr_q    <= '0;
         wtgt_q     <= '0;
         rpc_q      <= '0;
         miss_q     <= '0;
      end else begin
         wr_valid_q <= pop_ok;
         redir_q    <= miss;
         miss_q     <= miss_d;
         if (pop_ok) begin
            taken_q <= ResTaken_i;
            waddr_q <= head.addr;
            wtgt_q  <= word_align(ResTarget_i);
            rpc_q   <= ResTaken_i ? word_align(ResTarget_i)
                                  : head.addr + 32'd4;
         end
         unique case (state_q)
            S_NORMAL: if (miss) state_q <= S_FLUSH;
            S_FLUSH:  state_q <= S_NORMAL;
         endcase
      end
   end

   assign WriteValid_o  = wr_valid_q;
   assign Redirect_o    = redir_q;
   assign BranchTaken_o = taken_q;
   assign WriteAddr_o   = waddr_q;
   assign WriteTarget_o = wtgt_q;
   assign RedirectPc_o  = rpc_q;
   assign MissCount_o   = miss_q;

endmodule
